// File: rtl/reg_file.sv
// Two-read, one-write integer register file with a power-up clearing sweep.
// Optional write-to-read bypass is enabled by defining RF_WRB_BYPASS_EN.
//
// state | meaning
// INIT  | sweep clears x1..x31, one per cycle; writes dropped, reads return 0
// READY | normal operation; terminal until reset
module reg_file #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [4:0]      wrb_rd_addr_i,
   input  logic [XLEN-1:0] wrb_rd_data_i,
   input  logic            wrb_rd_wr_req_i,
   input  logic [4:0]      id_rs1_addr_i,
   input  logic [4:0]      id_rs2_addr_i,
   output logic [XLEN-1:0] rs1_data_o,
   output logic [XLEN-1:0] rs2_data_o,
   output logic            rf_ready_o
);

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_t;

   state_t          state;
   logic [4:0]      clr_idx;
   logic [XLEN-1:0] regs [NUM_REGS];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= INIT;
         clr_idx    <= 5'd1;
         rf_ready_o <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               clr_idx <= clr_idx + 5'd1;
               if (clr_idx == 5'd31) begin
                  state      <= READY;
                  rf_ready_o <= 1'b1;
               end
            end
            READY: begin
               state      <= READY;
               rf_ready_o <= 1'b1;
            end
            default: begin
               state      <= INIT;
               clr_idx    <= 5'd1;
               rf_ready_o <= 1'b0;
            end
         endcase
      end
   end

   // Storage has no reset of its own; the INIT sweep owns clearing it.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == INIT)
            regs[clr_idx] <= '0;
         else if (wrb_rd_wr_req_i && (wrb_rd_addr_i != 5'd0))
            regs[wrb_rd_addr_i] <= wrb_rd_data_i;
      end
   end

   always_comb begin
      rs1_data_o = '0;
      if ((state == READY) && (id_rs1_addr_i != 5'd0)) begin
         rs1_data_o = regs[id_rs1_addr_i];
`ifdef RF_WRB_BYPASS_EN
         if (wrb_rd_wr_req_i && (wrb_rd_addr_i == id_rs1_addr_i))
            rs1_data_o = wrb_rd_data_i;
`endif
      end
   end

   always_comb begin
      rs2_data_o = '0;
      if ((state == READY) && (id_rs2_addr_i != 5'd0)) begin
         rs2_data_o = regs[id_rs2_addr_i];
`ifdef RF_WRB_BYPASS_EN
         if (wrb_rd_wr_req_i && (wrb_rd_addr_i == id_rs2_addr_i))
            rs2_data_o = wrb_rd_data_i;
`endif
      end
   end

endmodule
